// File: rtl/sccpu_mem_bridge.sv
// sccpu_mem_bridge
//   Data-side memory/I-O bridge for the single-cycle CPU core. Decodes each
//   word access to the data RAM, the LED/switch port or a down-counting timer.
//   Reads are combinational, and writes commit on the rising clock edge.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   MemWrite   write strobe for the current cycle
//   addr       byte address (addr[1:0] ignored)
//   writedata  write data
//   readdata   combinational read data for addr
//   sw_in      asynchronous switch inputs (SW_W bits)
//   led_out    LED register (SW_W bits)
//   irq        timer interrupt = STATUS.TF & CTRL.IE
module sccpu_mem_bridge #(
  parameter int DEPTH = 1024,
  parameter int SW_W  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MemWrite,
  input  logic [31:0]     addr,
  input  logic [31:0]     writedata,
  output logic [31:0]     readdata,
  input  logic [SW_W-1:0] sw_in,
  output logic [SW_W-1:0] led_out,
  output logic            irq
);

  localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [12:0] DEPTH_W = 13'(DEPTH);

  // Word offsets (addr[14:2]) of the I/O registers.
  localparam logic [12:0] OFS_LED    = 13'h1FC0; // 0x7F00
  localparam logic [12:0] OFS_SW     = 13'h1FC1; // 0x7F04
  localparam logic [12:0] OFS_CTRL   = 13'h1FC4; // 0x7F10
  localparam logic [12:0] OFS_PRESET = 13'h1FC5; // 0x7F14
  localparam logic [12:0] OFS_COUNT  = 13'h1FC6; // 0x7F18
  localparam logic [12:0] OFS_STATUS = 13'h1FC7; // 0x7F1C

  logic [31:0]     mem [DEPTH];
  logic [SW_W-1:0] led_reg;
  logic [SW_W-1:0] s1_reg;
  logic [SW_W-1:0] s2_reg;
  logic [2:0]      ctrl_reg;
  logic [31:0]     preset_reg;
  logic [31:0]     count_reg;
  logic            tf_reg;

  logic [31:0] count_next;
  logic        expire;

  // addr[1:0] only selects a byte lane, which this bridge never uses.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^addr[1:0];

  logic [12:0]   word_ofs;
  logic          in_window;
  logic          is_ram;
  logic [AW-1:0] ram_idx;

  assign word_ofs  = addr[14:2];
  assign in_window = (addr[31:15] == 17'd0);
  assign is_ram    = in_window && (word_ofs < DEPTH_W);
  assign ram_idx   = addr[AW+1:2];

  logic wr_led, wr_ctrl, wr_preset, wr_status;
  assign wr_led    = MemWrite && in_window && (word_ofs == OFS_LED);
  assign wr_ctrl   = MemWrite && in_window && (word_ofs == OFS_CTRL);
  assign wr_preset = MemWrite && in_window && (word_ofs == OFS_PRESET);
  assign wr_status = MemWrite && in_window && (word_ofs == OFS_STATUS);

  // Data RAM: contents are never reset.
  always_ff @(posedge clk) begin
    if (MemWrite && is_ram) begin
      mem[ram_idx] <= writedata;
    end
  end

  // Timer step, computed from the current (pre-edge) CTRL so that a CTRL
  // write only affects the following edge.
  assign expire = ctrl_reg[0] && (count_reg == 32'd1);

  always_comb begin
    count_next = count_reg;
    if (wr_preset) begin
      count_next = writedata;          // a PRESET write overrides the step
    end else if (ctrl_reg[0] && (count_reg > 32'd1)) begin
      count_next = count_reg - 32'd1;
    end else if (expire) begin
      count_next = ctrl_reg[1] ? preset_reg : 32'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_reg    <= '0;
      s1_reg     <= '0;
      s2_reg     <= '0;
      ctrl_reg   <= '0;
      preset_reg <= '0;
      count_reg  <= '0;
      tf_reg     <= 1'b0;
    end else begin
      s1_reg    <= sw_in;
      s2_reg    <= s1_reg;
      count_reg <= count_next;
      if (wr_led)    led_reg    <= writedata[SW_W-1:0];
      if (wr_ctrl)   ctrl_reg   <= writedata[2:0];
      if (wr_preset) preset_reg <= writedata;
      // Expiry has priority over a same-edge write-1-to-clear.
      if (expire) begin
        tf_reg <= 1'b1;
      end else if (wr_status && writedata[0]) begin
        tf_reg <= 1'b0;
      end
    end
  end

  assign led_out = led_reg;
  assign irq     = tf_reg & ctrl_reg[2];

  always_comb begin
    readdata = 32'd0;
    if (is_ram) begin
      readdata = mem[ram_idx];
    end else if (in_window) begin
      case (word_ofs)
        OFS_LED:    readdata = 32'(led_reg);
        OFS_SW:     readdata = 32'(s2_reg);
        OFS_CTRL:   readdata = {29'd0, ctrl_reg};
        OFS_PRESET: readdata = preset_reg;
        OFS_COUNT:  readdata = count_reg;
        OFS_STATUS: readdata = {31'd0, tf_reg};
        default:    readdata = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_sccpu_mem_bridge.sv
module tb_sccpu_mem_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemWrite;
  logic [31:0] addr;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [15:0] sw_in;
  logic [15:0] led_out;
  logic        irq;

  int checks   = 0;
  int failures = 0;

  localparam logic [31:0] A_LED    = 32'h7F00;
  localparam logic [31:0] A_SW     = 32'h7F04;
  localparam logic [31:0] A_CTRL   = 32'h7F10;
  localparam logic [31:0] A_PRESET = 32'h7F14;
  localparam logic [31:0] A_COUNT  = 32'h7F18;
  localparam logic [31:0] A_STATUS = 32'h7F1C;

  sccpu_mem_bridge #(.DEPTH(1024), .SW_W(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .MemWrite  (MemWrite),
    .addr      (addr),
    .writedata (writedata),
    .readdata  (readdata),
    .sw_in     (sw_in),
    .led_out   (led_out),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] d;   // write data, or expected read data when we=0
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end else begin
      $display("ok   %s: %08h", nm, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    MemWrite  = 1'b1;
    addr      = a;
    writedata = d;
    $display("wr   %08h <= %08h", a, d);
    step();
    MemWrite = 1'b0;
  endtask

  task automatic rd(input string nm, input logic [31:0] a, input logic [31:0] exp);
    MemWrite = 1'b0;
    addr     = a;
    #1;
    chk(nm, readdata, exp);
  endtask

  initial begin
    rst = 1'b1; MemWrite = 1'b0; addr = '0; writedata = '0; sw_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset led_out", 32'(led_out), 32'd0);
    chk("reset irq", 32'(irq), 32'd0);
    rst = 1'b0;
    rd("reset CTRL",   A_CTRL,   32'd0);
    rd("reset PRESET", A_PRESET, 32'd0);
    rd("reset COUNT",  A_COUNT,  32'd0);
    rd("reset STATUS", A_STATUS, 32'd0);
    rd("reset SW",     A_SW,     32'd0);
    step();

    // ---------------- table-driven RAM / LED / unmapped ----------------
    vecs.push_back('{1'b1, 32'h0010, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h0014, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0013, 32'hDEADBEEF});
    vecs.push_back('{1'b0, 32'h0014, 32'h12345678});
    vecs.push_back('{1'b0, 32'h0010, 32'hDEADBEEF});
    vecs.push_back('{1'b1, 32'h0FFC, 32'h00000005});
    vecs.push_back('{1'b1, 32'h1000, 32'hAAAA5555});
    vecs.push_back('{1'b0, 32'h0FFC, 32'h00000005});
    vecs.push_back('{1'b0, 32'h1000, 32'h00000000});
    vecs.push_back('{1'b1, A_LED,    32'hFFFFA5A5});
    vecs.push_back('{1'b0, A_LED,    32'h0000A5A5});
    vecs.push_back('{1'b1, 32'h8000, 32'h11111111});
    vecs.push_back('{1'b0, 32'h8000, 32'h00000000});
    vecs.push_back('{1'b0, A_LED,    32'h0000A5A5});
    vecs.push_back('{1'b1, A_SW,     32'h0000FFFF});
    vecs.push_back('{1'b0, A_SW,     32'h00000000});
    vecs.push_back('{1'b1, A_CTRL,   32'hFFFFFFF8});
    vecs.push_back('{1'b0, A_CTRL,   32'h00000000});
    vecs.push_back('{1'b1, A_CTRL,   32'h00000006});
    vecs.push_back('{1'b0, A_CTRL,   32'h00000006});
    vecs.push_back('{1'b1, A_CTRL,   32'h00000000});
    vecs.push_back('{1'b0, 32'h7F08, 32'h00000000});
    vecs.push_back('{1'b0, 32'h7F20, 32'h00000000});
    vecs.push_back('{1'b0, A_COUNT,  32'h00000000});

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].we) begin
        wr(vecs[i].a, vecs[i].d);
      end else begin
        rd($sformatf("vec[%0d] rd %08h", i, vecs[i].a), vecs[i].a, vecs[i].d);
        step();
      end
    end
    chk("led_out port", 32'(led_out), 32'h0000A5A5);

    // ---------------- switch synchroniser ----------------
    sw_in = 16'h00F0;
    step();
    rd("SW after 1 edge", A_SW, 32'h00000000);
    step();
    rd("SW after 2 edges", A_SW, 32'h000000F0);

    // ---------------- one-shot timer ----------------
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'b101);
    rd("oneshot count 3", A_COUNT, 32'd3);
    step();
    rd("oneshot count 2", A_COUNT, 32'd2);
    step();
    rd("oneshot count 1", A_COUNT, 32'd1);
    rd("oneshot TF before", A_STATUS, 32'd0);
    chk("oneshot irq before", 32'(irq), 32'd0);
    step();
    rd("oneshot count 0", A_COUNT, 32'd0);
    rd("oneshot TF set", A_STATUS, 32'd1);
    chk("oneshot irq set", 32'(irq), 32'd1);
    step();
    rd("oneshot count hold", A_COUNT, 32'd0);
    wr(A_STATUS, 32'd0);
    rd("W0 keeps TF", A_STATUS, 32'd1);
    wr(A_STATUS, 32'd1);
    rd("W1C clears TF", A_STATUS, 32'd0);
    chk("irq dropped", 32'(irq), 32'd0);

    // ---------------- auto-reload ----------------
    wr(A_CTRL, 32'd0);
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'b111);
    rd("ar count 2", A_COUNT, 32'd2);
    step();
    rd("ar count 1", A_COUNT, 32'd1);
    step();
    rd("ar reload 2", A_COUNT, 32'd2);
    rd("ar TF set", A_STATUS, 32'd1);
    wr(A_STATUS, 32'd1);              // count 2 -> 1, clear applies
    rd("ar count 1b", A_COUNT, 32'd1);
    rd("ar TF cleared", A_STATUS, 32'd0);
    wr(A_STATUS, 32'd1);              // expiry on this edge: set wins
    rd("ar set wins TF", A_STATUS, 32'd1);
    rd("ar reload 2b", A_COUNT, 32'd2);
    chk("ar irq", 32'(irq), 32'd1);

    // ---------------- collisions ----------------
    wr(A_CTRL, 32'd0);                // old EN still steps: 2 -> 1
    wr(A_STATUS, 32'd1);
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'd1);
    rd("col count 5", A_COUNT, 32'd5);
    wr(A_PRESET, 32'd9);
    rd("col write wins", A_COUNT, 32'd9);
    wr(A_CTRL, 32'd0);                // same-edge step uses old EN: 9 -> 8
    rd("col last step", A_COUNT, 32'd8);
    for (int i = 0; i < 10; i++) begin
      step();
      rd($sformatf("hold cycle %0d", i), A_COUNT, 32'd8);
    end

    // ---------------- reset mid-operation ----------------
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'b111);
    step();
    step();
    rd("pre-rst TF", A_STATUS, 32'd1);
    chk("pre-rst irq", 32'(irq), 32'd1);
    chk("pre-rst led", 32'(led_out), 32'h0000A5A5);
    #1;
    rst = 1'b1;
    #1;
    chk("rst led_out", 32'(led_out), 32'd0);
    chk("rst irq", 32'(irq), 32'd0);
    rd("rst COUNT",  A_COUNT,  32'd0);
    rd("rst PRESET", A_PRESET, 32'd0);
    rd("rst CTRL",   A_CTRL,   32'd0);
    rd("rst STATUS", A_STATUS, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (3) step();
    rd("post-rst COUNT",  A_COUNT,  32'd0);
    rd("post-rst STATUS", A_STATUS, 32'd0);
    chk("post-rst irq", 32'(irq), 32'd0);
    rd("RAM kept over reset", 32'h0010, 32'hDEADBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
